// File: rtl/sprite_pixel_renderer.sv
// Sprite renderer: VGA scan coordinate -> 16x16 ROM address, pose select, chroma-key composite over background.
// Latency fixed at 2 Clk from DrawX/DrawY/bg_rgb to pix_rgb/pix_hit; one pixel per cycle, never stalls.
module sprite_pixel_renderer #(
  parameter int unsigned SCALE_LOG2  = 1,
  parameter logic [23:0] KEY_RGB     = 24'hFFD700,
  parameter int unsigned ANIM_FRAMES = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  PosX,
  input  logic [9:0]  PosY,
  input  logic        moving,
  input  logic        face_left,
  input  logic [23:0] bg_rgb,
  output logic [7:0]  rom_addr,
  output logic        rom_switch,
  input  logic [23:0] rom_rgb,
  output logic [23:0] pix_rgb,
  output logic        pix_hit
);

  localparam logic [10:0] BOX_SIZE  = 11'(16 << SCALE_LOG2);
  localparam logic [7:0]  ANIM_LAST = 8'(ANIM_FRAMES - 1);

  logic        frame_clk_q;
  logic        fr_edge;
  logic [9:0]  pos_x_l;
  logic [9:0]  pos_y_l;
  logic        face_left_l;
  logic [7:0]  anim_cnt;

  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_box;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  col_eff;

  logic        in_box_q;
  logic [23:0] bg_q;
  logic        opaque;

  assign fr_edge = frame_clk & ~frame_clk_q;

  // Position/orientation only move at frame boundaries so a frame never tears.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_clk_q <= 1'b0;
      pos_x_l     <= 10'd0;
      pos_y_l     <= 10'd0;
      face_left_l <= 1'b1;
      anim_cnt    <= 8'd0;
      rom_switch  <= 1'b1;
    end else begin
      frame_clk_q <= frame_clk;
      if (fr_edge) begin
        pos_x_l     <= PosX;
        pos_y_l     <= PosY;
        face_left_l <= face_left;
        if (moving) begin
          if (anim_cnt == ANIM_LAST) begin
            anim_cnt   <= 8'd0;
            rom_switch <= ~rom_switch;
          end else begin
            anim_cnt <= anim_cnt + 8'd1;
          end
        end else begin
          anim_cnt   <= 8'd0;
          rom_switch <= 1'b1;
        end
      end
    end
  end

  // 11-bit compare keeps the box clipped at column/row 1023 instead of wrapping.
  always_comb begin
    dx      = {1'b0, DrawX} - {1'b0, pos_x_l};
    dy      = {1'b0, DrawY} - {1'b0, pos_y_l};
    in_box  = (DrawX >= pos_x_l) && (dx < BOX_SIZE) &&
              (DrawY >= pos_y_l) && (dy < BOX_SIZE);
    col     = dx[SCALE_LOG2+3 -: 4];
    row     = dy[SCALE_LOG2+3 -: 4];
    col_eff = face_left_l ? col : (4'd15 - col);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= 8'd0;
      in_box_q <= 1'b0;
      bg_q     <= 24'd0;
    end else begin
      rom_addr <= in_box ? {row, col_eff} : 8'd0;
      in_box_q <= in_box;
      bg_q     <= bg_rgb;
    end
  end

  assign opaque = in_box_q && (rom_rgb != KEY_RGB);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_rgb <= 24'd0;
      pix_hit <= 1'b0;
    end else begin
      pix_rgb <= opaque ? rom_rgb : bg_q;
      pix_hit <= opaque;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_renderer.sv
// Bench for sprite_pixel_renderer: directed scenarios then randomized traffic against a frame-level pixel model.
module tb_sprite_pixel_renderer;

  localparam int          S     = 1;
  localparam int          SIZE  = 16 << S;
  localparam int          ANIM  = 8;
  localparam logic [23:0] KEY   = 24'hFFD700;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  PosX;
  logic [9:0]  PosY;
  logic        moving;
  logic        face_left;
  logic [23:0] bg_rgb;
  logic [7:0]  rom_addr;
  logic        rom_switch;
  logic [23:0] rom_rgb;
  logic [23:0] pix_rgb;
  logic        pix_hit;

  logic [23:0] rom_mem [512];
  assign rom_rgb = rom_mem[{rom_switch, rom_addr}];

  sprite_pixel_renderer #(
    .SCALE_LOG2 (S),
    .KEY_RGB    (KEY),
    .ANIM_FRAMES(ANIM)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .PosX      (PosX),
    .PosY      (PosY),
    .moving    (moving),
    .face_left (face_left),
    .bg_rgb    (bg_rgb),
    .rom_addr  (rom_addr),
    .rom_switch(rom_switch),
    .rom_rgb   (rom_rgb),
    .pix_rgb   (pix_rgb),
    .pix_hit   (pix_hit)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: what the sprite looks like for the frame currently on screen
  int          m_px, m_py, m_cnt;
  logic        m_face, m_sw, m_fcq;
  logic [7:0]  exp_addr;
  logic [23:0] exp_pix, pend_pix;
  logic        exp_hit, pend_hit;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_cnt = 0;
    m_face = 1'b1; m_sw = 1'b1; m_fcq = 1'b0;
    exp_addr = 8'd0; exp_pix = 24'd0; exp_hit = 1'b0;
    pend_pix = 24'd0; pend_hit = 1'b0;
  endtask

  // One Clk cycle: predict from the inputs now on the pins, clock, then compare.
  task automatic tick();
    int dx, dy, col, row;
    logic inb, fe, h;
    logic [7:0] a;
    logic [23:0] c;
    if (Reset) begin
      model_reset();
    end else begin
      dx  = int'(DrawX) - m_px;
      dy  = int'(DrawY) - m_py;
      inb = (dx >= 0) && (dx < SIZE) && (dy >= 0) && (dy < SIZE);
      col = dx / (1 << S);
      row = dy / (1 << S);
      if (!m_face) col = 15 - col;
      a   = inb ? 8'(row * 16 + col) : 8'd0;
      fe  = frame_clk && !m_fcq;
      m_fcq = frame_clk;
      if (fe) begin
        m_px = int'(PosX); m_py = int'(PosY); m_face = face_left;
        if (moving) begin
          m_cnt++;
          if (m_cnt == ANIM) begin
            m_cnt = 0;
            m_sw  = !m_sw;
          end
        end else begin
          m_cnt = 0;
          m_sw  = 1'b1;
        end
      end
      c = rom_mem[{m_sw, a}];
      h = inb && (c != KEY);
      if (!h) c = bg_rgb;
      exp_pix  = pend_pix;
      exp_hit  = pend_hit;
      pend_pix = c;
      pend_hit = h;
      exp_addr = a;
    end
    @(posedge Clk);
    @(negedge Clk);
    check("addr", rom_addr, exp_addr);
    check("switch", rom_switch, m_sw);
    check("pix", pix_rgb, exp_pix);
    check("hit", pix_hit, exp_hit);
  endtask

  task automatic pulse();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 512; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
    model_reset();
    Reset = 1'b1;
    frame_clk = 1'b0;
    DrawX = '0; DrawY = '0; PosX = '0; PosY = '0;
    moving = 1'b0; face_left = 1'b1; bg_rgb = '0;

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      DrawX = 10'($urandom); DrawY = 10'($urandom);
      PosX = 10'($urandom); PosY = 10'($urandom);
      moving = 1'($urandom); face_left = 1'($urandom);
      frame_clk = 1'($urandom); bg_rgb = 24'($urandom);
      tick();
      check("rst_addr", rom_addr, 24'd0);
      check("rst_switch", rom_switch, 24'd1);
      check("rst_pix", pix_rgb, 24'd0);
      check("rst_hit", pix_hit, 24'd0);
    end
    Reset = 1'b0; frame_clk = 1'b0; moving = 1'b0;
    DrawX = 10'd500; DrawY = 10'd500;
    tick();
    check("rel_addr", rom_addr, 24'd0);
    check("rel_switch", rom_switch, 24'd1);
    check("rel_pix", pix_rgb, 24'd0);
    check("rel_hit", pix_hit, 24'd0);

    // latency and compositing
    PosX = 10'd100; PosY = 10'd50; face_left = 1'b1; moving = 1'b0;
    pulse();
    rom_mem[{1'b1, 8'h11}] = 24'hFF0000;
    DrawX = 10'd102; DrawY = 10'd53; bg_rgb = 24'hABCDEF;
    tick();
    check("lat_addr", rom_addr, 24'h11);
    DrawX = 10'd500;
    tick();
    check("lat_pix", pix_rgb, 24'hFF0000);
    check("lat_hit", pix_hit, 24'd1);

    // transparency, then a pixel just outside the box
    rom_mem[{1'b1, 8'h11}] = KEY;
    DrawX = 10'd102; DrawY = 10'd53; bg_rgb = 24'h123456;
    tick();
    tick();
    check("key_pix", pix_rgb, 24'h123456);
    check("key_hit", pix_hit, 24'd0);
    DrawX = 10'd99; bg_rgb = 24'h0BEEF0;
    tick();
    check("out_addr", rom_addr, 24'd0);
    bg_rgb = 24'h111111;
    tick();
    check("out_pix", pix_rgb, 24'h0BEEF0);
    check("out_hit", pix_hit, 24'd0);

    // mirroring
    face_left = 1'b0;
    pulse();
    DrawX = 10'd100; DrawY = 10'd50;
    tick();
    check("mir_col0", rom_addr, 24'h0F);
    DrawX = 10'd131;
    tick();
    check("mir_col15", rom_addr, 24'h00);
    DrawX = 10'd128; DrawY = 10'd52;
    tick();
    check("mir_col14", rom_addr, 24'h11 - 24'h10 + 24'h10);

    // animation
    moving = 1'b1;
    repeat (7) pulse();
    check("anim_7", rom_switch, 24'd1);
    frame_clk = 1'b1;
    tick();
    check("anim_8", rom_switch, 24'd0);
    frame_clk = 1'b0;
    tick();
    repeat (8) pulse();
    check("anim_16", rom_switch, 24'd1);
    repeat (11) pulse();
    check("anim_27", rom_switch, 24'd0);
    moving = 1'b0;
    pulse();
    check("anim_stop", rom_switch, 24'd1);
    moving = 1'b1;
    repeat (7) pulse();
    check("anim_restart7", rom_switch, 24'd1);
    pulse();
    check("anim_restart8", rom_switch, 24'd0);

    // frame latch
    moving = 1'b0; face_left = 1'b1; PosX = 10'd100; PosY = 10'd50;
    pulse();
    PosX = 10'd200; DrawX = 10'd102; DrawY = 10'd53;
    tick();
    check("latch_hold", rom_addr, 24'h11);
    pulse();
    tick();
    check("latch_old_out", rom_addr, 24'h00);
    DrawX = 10'd202;
    tick();
    check("latch_new", rom_addr, 24'h11);

    // right-edge clipping
    PosX = 10'd1015;
    pulse();
    DrawX = 10'd1023; DrawY = 10'd50;
    tick();
    check("clip_1023", rom_addr, 24'h04);
    DrawX = 10'd0;
    tick();
    check("clip_wrap", rom_addr, 24'h00);

    // randomized traffic around the sprite
    for (int i = 0; i < 512; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        PosX = ($urandom_range(0, 3) == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom);
        PosY = ($urandom_range(0, 3) == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom);
      end
      if ($urandom_range(0, 31) == 0) moving = ~moving;
      if ($urandom_range(0, 15) == 0) face_left = ~face_left;
      frame_clk = ($urandom_range(0, 5) == 0);
      Reset = ($urandom_range(0, 599) == 0);
      DrawX = 10'(m_px + $urandom_range(0, 40) - 4);
      DrawY = 10'(m_py + $urandom_range(0, 40) - 4);
      bg_rgb = 24'($urandom);
      tick();
    end
    Reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_renderer.md
Name: sprite_pixel_renderer

Overview:
Downstream stage of the 16x16 character sprite ROM.
- Maps the VGA scan coordinate into a ROM address.
- Selects the animation pose through the ROM's switch input.
- Applies chroma-key transparency and horizontal mirroring.
- Composites the sprite over the background pixel, with a fixed 2-cycle pipeline from DrawX/DrawY to the output colour.

Parameters:
SCALE_LOG2, 1, sprite magnification as a power of two (on-screen size = 16 << SCALE_LOG2 pixels per side)
KEY_RGB, 24'hFFD700, transparent colour; exact 24-bit match required
ANIM_FRAMES, 8, number of frame_clk rising edges per pose toggle while moving (2..255)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  vertical-sync-rate strobe; sampled on Clk, rising edge detected internally
DrawX  in  10  current scan column
DrawY  in  10  current scan row
PosX  in  10  sprite top-left column (live value from motion logic)
PosY  in  10  sprite top-left row
moving  in  1  character is walking (enables animation)
face_left  in  1  1 = left-facing (ROM native orientation), 0 = mirrored
bg_rgb  in  24  background colour for DrawX/DrawY, presented in the same cycle as DrawX/DrawY
rom_addr  out  8  registered ROM address {row[3:0], col[3:0]}
rom_switch  out  1  registered pose select to ROM (1 = primary pose)
rom_rgb  in  24  combinational ROM data for rom_addr
pix_rgb  out  24  composited pixel colour
pix_hit  out  1  1 when pix_rgb came from an opaque sprite texel

Behaviour:
- **Reset values:** all flops reset asynchronously:
  - rom_addr=0, rom_switch=1, pix_rgb=0, pix_hit=0
  - anim counter=0, latched PosX/PosY=0, latched face_left=1
  - frame_clk edge-detect flop=0, stage-1 valid/bg regs=0
- **Frame edge:** fr_edge = frame_clk & ~frame_clk_q (one Clk cycle).
- **Frame latch:** PosX, PosY and face_left are captured into shadow registers only on fr_edge. All rendering uses the shadow values, so no mid-frame tearing.
- **Animation counter (8 bit):**
  - On fr_edge with moving=1: if counter==ANIM_FRAMES-1, wrap to 0 and toggle rom_switch; else increment.
  - On fr_edge with moving=0: counter<=0 and rom_switch<=1.
  - Without fr_edge: hold.
  - rom_switch never changes except on fr_edge.
- **Stage 1 (cycle 0 -> registered at end of cycle 0):**
  - dx = {1'b0,DrawX} - {1'b0,PosX_l} and dy likewise, both 11 bit.
  - in_box = DrawX >= PosX_l AND dx < (16<<SCALE_LOG2), with the same test for Y. Compare in 11 bits; the box clips at 1023 and never wraps to column 0.
  - col = dx[SCALE_LOG2+3:SCALE_LOG2], row = dy[SCALE_LOG2+3:SCALE_LOG2].
  - col_eff = face_left_l ? col : 15-col.
  - rom_addr <= in_box ? {row,col_eff} : 8'd0.
  - in_box_q <= in_box; bg_q <= bg_rgb.
- **ROM access (cycle 1):** the ROM is combinational, so rom_rgb is valid during cycle 1.
- **Stage 2 (registered at end of cycle 1):**
  - opaque = in_box_q AND (rom_rgb != KEY_RGB).
  - pix_rgb <= opaque ? rom_rgb : bg_q; pix_hit <= opaque.
- **Latency:** exactly 2 Clk cycles from DrawX/DrawY/bg_rgb to pix_rgb/pix_hit. Fully pipelined with one pixel per cycle and no stalls.
- **Simultaneous events:** a pixel in flight when fr_edge occurs uses the shadow values present when it entered stage 1. A new rom_switch is seen by the ROM from the cycle after fr_edge.
- **Reset mid-frame:** outputs go to reset values immediately. The pipeline refills after 2 cycles. Sprite position reads as 0,0 until the next fr_edge.

Test Plan:
- **Reset/idle:** assert Reset with random inputs -> rom_addr=0, rom_switch=1, pix_rgb=0, pix_hit=0 while Reset high and 1 cycle after release.
- **Latency/compose:**
  - Setup: PosX=100, PosY=50, SCALE_LOG2=1, pulse frame_clk, face_left=1.
  - Drive DrawX=102, DrawY=53, ROM model returns 24'hFF0000 for addr {4'd1,4'd1}.
  - Expected: rom_addr=8'h11 after 1 cycle; pix_rgb=FF0000, pix_hit=1 after 2 cycles.
- **Transparency:** same pixel with ROM returning FFD700 and bg_rgb=123456 -> pix_rgb=123456, pix_hit=0. With DrawX=99 (outside box) -> rom_addr=0, pix_rgb=bg.
- **Mirror:** face_left=0 latched, DrawX=PosX (col 0), DrawY=PosY -> rom_addr=8'h0F; DrawX=PosX+31 -> rom_addr=8'h00.
- **Animation:**
  - moving=1, ANIM_FRAMES=8: 8 frame_clk pulses -> rom_switch toggles to 0 exactly on the 8th edge; 16 pulses -> back to 1.
  - Drop moving mid-count and pulse once -> rom_switch=1, counter restarts at 0.
- **Frame latch and edge clipping:**
  - Change PosX mid-frame without a frame_clk pulse -> addresses unchanged; they change after the pulse.
  - PosX=1015 -> DrawX=1023 in box with col=4, DrawX=0 not in box.
